bcd2hex_top: RTL and testbench

- Inverse of the stopwatch binary-to-BCD display path. Takes four edited BCD digits (high pair a/b, low pair c/d) and converts them back into the binary preset values h_val (0..59) and l_val (0..99).
- Used when the user loads a preset time into the stopwatch counters.
- Conversion is serial, using one shared reverse double-dabble shifter that is time-multiplexed over both digit pairs.
- Launched by a falling edge on start; same sequencing style as the forward converter.

---
 rtl/bcd2hex_top.sv | 145 ++++++++++++++
 tb/tb_bcd2hex_top.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2hex_top.sv
`default_nettype none
// ============================================================================
// Module   : bcd2hex_top
// Purpose  : Converts four edited BCD digits back into binary preset values
//            for the stopwatch counters. One reverse double-dabble shifter
//            is shared serially: pair a/b first (h_val), then pair c/d (l_val).
//            A falling edge on start launches a conversion; a new falling
//            edge during a conversion restarts it.
// Ports    :
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   start         in   conversion request, falling edge launches
//   bcd_a/bcd_b   in   high pair tens/ones digit
//   bcd_c/bcd_d   in   low pair tens/ones digit
//   h_val [5:0]   out  binary a*10+b (0..59)
//   l_val [6:0]   out  binary c*10+d (0..99)
//   busy          out  conversion in progress (cnt 0..16)
//   done          out  completion window (cnt 17..30), qualify with err
//   err           out  last conversion rejected
// Revision : 1.0 - initial release
// ============================================================================
module bcd2hex_top #(
    parameter logic [6:0] H_MAX    = 7'd59,
    parameter logic [4:0] CNT_IDLE = 5'd31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] bcd_a,
    input  logic [3:0] bcd_b,
    input  logic [3:0] bcd_c,
    input  logic [3:0] bcd_d,
    output logic [5:0] h_val,
    output logic [6:0] l_val,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [4:0] c_CNT_LOAD_A  = 5'd0;
    localparam logic [4:0] c_CNT_LOAD_C  = 5'd8;
    localparam logic [4:0] c_CNT_COMMIT  = 5'd16;
    localparam logic [4:0] c_CNT_DONE_LO = 5'd17;

    // One reverse double-dabble step on {tens, ones, bin}: shift right, then
    // correct each digit that received a carried-in weight of 8 (worth 5).
    function automatic logic [14:0] dabble_step(input logic [14:0] s);
        logic [14:0] t;
        t = s >> 1;
        if (t[14:11] >= 4'd8) t[14:11] = t[14:11] - 4'd3;
        if (t[10:7]  >= 4'd8) t[10:7]  = t[10:7]  - 4'd3;
        return t;
    endfunction

    function automatic logic pair_bad(input logic [3:0] tens, input logic [3:0] ones);
        return (tens > 4'd9) || (ones > 4'd9);
    endfunction

    logic        r_st0;
    logic        r_st1;
    logic [4:0]  r_cnt;
    logic [14:0] r_sh;
    logic [5:0]  r_hv_tmp;
    logic        r_flag;
    logic [5:0]  r_h_val;
    logic [6:0]  r_l_val;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_launch;
    logic [4:0]  w_cnt_nxt;
    logic [14:0] w_iter;

    assign w_launch = r_st1 & ~r_st0;
    assign w_iter   = dabble_step(r_sh);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_launch) begin
            w_cnt_nxt = c_CNT_LOAD_A;
        end else if (r_cnt < CNT_IDLE) begin
            w_cnt_nxt = r_cnt + 5'd1;
        end
    end

    // Start history resets to 1 so a start held low through reset release
    // still looks like a falling edge and runs one conversion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st0  <= 1'b1;
            r_st1  <= 1'b1;
            r_cnt  <= CNT_IDLE;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_st0  <= start;
            r_st1  <= r_st0;
            r_cnt  <= w_cnt_nxt;
            // Status flags follow the next count so they align with it.
            r_busy <= (w_cnt_nxt <= c_CNT_COMMIT);
            r_done <= (w_cnt_nxt >= c_CNT_DONE_LO) && (w_cnt_nxt < CNT_IDLE);
        end
    end

    // Shifter sequencing. r_flag accumulates every reason to reject the
    // conversion; it is reloaded at each pair-A load so a restart starts clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh     <= '0;
            r_hv_tmp <= '0;
            r_flag   <= 1'b0;
            r_h_val  <= '0;
            r_l_val  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_cnt == c_CNT_LOAD_A) begin
                r_sh   <= {bcd_a, bcd_b, 7'd0};
                r_flag <= pair_bad(bcd_a, bcd_b);
            end else if (r_cnt == c_CNT_LOAD_C) begin
                r_hv_tmp <= r_sh[5:0];
                r_flag   <= r_flag | (r_sh[6:0] > H_MAX) | pair_bad(bcd_c, bcd_d);
                r_sh     <= {bcd_c, bcd_d, 7'd0};
            end else if (r_cnt == c_CNT_COMMIT) begin
                if (!r_flag) begin
                    r_h_val <= r_hv_tmp;
                    r_l_val <= r_sh[6:0];
                    r_err   <= 1'b0;
                end else begin
                    r_err   <= 1'b1;
                end
            end else if (r_cnt < c_CNT_COMMIT) begin
                r_sh <= w_iter;
            end
        end
    end

    assign h_val = r_h_val;
    assign l_val = r_l_val;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd2hex_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd2hex_top
// Purpose  : Self-checking bench for bcd2hex_top. Expected values come from an
//            arithmetic model (a*10+b, c*10+d, digit and range rejection).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd2hex_top;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] bcd_a, bcd_b, bcd_c, bcd_d;
    logic [5:0] h_val;
    logic [6:0] l_val;
    logic       busy, done, err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int exp_h = 0;
    int exp_l = 0;
    bit exp_err = 1'b0;

    bcd2hex_top dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd_a (bcd_a),
        .bcd_b (bcd_b),
        .bcd_c (bcd_c),
        .bcd_d (bcd_d),
        .h_val (h_val),
        .l_val (l_val),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_conv(input int a, input int b, input int c, input int d);
        int h, l;
        h = a * 10 + b;
        l = c * 10 + d;
        if (a > 9 || b > 9 || c > 9 || d > 9 || h > 59) begin
            exp_err = 1'b1;
        end else begin
            exp_h   = h;
            exp_l   = l;
            exp_err = 1'b0;
        end
    endtask

    // Drops start for one sample; returns at the negedge after the sampling edge.
    task automatic pulse_start(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
        @(negedge clk);
        bcd_a = a; bcd_b = b; bcd_c = c; bcd_d = d;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
    endtask

    // Runs one conversion, scrambles the digits once both pairs are sampled,
    // and reports what the outputs show on the first done cycle.
    task automatic run_conv(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d,
                            output logic [5:0] h, output logic [6:0] l,
                            output logic e, output int lat, output bit ok);
        pulse_start(a, b, c, d);
        ok  = 1'b0;
        lat = 0;
        h = '0; l = '0; e = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bcd_a = 4'($urandom); bcd_b = 4'($urandom);
        bcd_c = 4'($urandom); bcd_d = 4'($urandom);
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = 10 + i;
                h = h_val; l = l_val; e = err;
                ok = 1'b1;
                break;
            end
        end
        // let the done window expire before the next request
        repeat (16) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1;
        bcd_a = 4'd0; bcd_b = 4'd0; bcd_c = 4'd0; bcd_d = 4'd0;
        repeat (3) @(posedge clk); #1;
        checks++; if (h_val !== 6'd0) begin errors++; $display("FAIL reset_h_val got=%0d exp=0", h_val); end
        checks++; if (l_val !== 7'd0) begin errors++; $display("FAIL reset_l_val got=%0d exp=0", l_val); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
        @(negedge clk); rst = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 25; i++) begin
                @(posedge clk); #1;
                if (busy || done) seen++;
            end
            checks++; if (seen != 0) begin errors++; $display("FAIL reset_idle busy_or_done_cycles=%0d exp=0", seen); end
        end
    endtask

    task automatic test_basic();
        int busy_cnt = 0, done_cnt = 0, first_done = 0;
        logic [5:0] h; logic [6:0] l; logic e;
        h = '0; l = '0; e = 1'b0;
        pulse_start(4'd5, 4'd9, 4'd9, 4'd9);
        model_conv(5, 9, 9, 9);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (first_done == 0) begin first_done = i; h = h_val; l = l_val; e = err; end
            end
        end
        checks++; if (busy_cnt != 17) begin errors++; $display("FAIL basic_busy_len got=%0d exp=17", busy_cnt); end
        checks++; if (done_cnt != 14) begin errors++; $display("FAIL basic_done_len got=%0d exp=14", done_cnt); end
        checks++; if (first_done != 18) begin errors++; $display("FAIL basic_latency got=%0d exp=18", first_done); end
        checks++; if ({h, l, e} !== {6'(exp_h), 7'(exp_l), exp_err}) begin
            errors++; $display("FAIL basic_value got=%0d/%0d err=%b exp=%0d/%0d err=%b", h, l, e, exp_h, exp_l, exp_err);
        end
    endtask

    task automatic test_vectors();
        // directed sequences: shifter clearing, range reject, digit reject, recovery
        logic [3:0] vec [0:6][0:3];
        logic [5:0] h; logic [6:0] l; logic e; int lat; bit ok;
        vec[0] = '{4'd0, 4'd0, 4'd0, 4'd7};
        vec[1] = '{4'd2, 4'd3, 4'd4, 4'd0};
        vec[2] = '{4'd1, 4'd2, 4'd3, 4'd4};
        vec[3] = '{4'd6, 4'd0, 4'd1, 4'd2};
        vec[4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        vec[5] = '{4'd1, 4'd2, 4'd3, 4'hA};
        vec[6] = '{4'd1, 4'd0, 4'd2, 4'd5};
        for (int v = 0; v < 7; v++) begin
            run_conv(vec[v][0], vec[v][1], vec[v][2], vec[v][3], h, l, e, lat, ok);
            model_conv(vec[v][0], vec[v][1], vec[v][2], vec[v][3]);
            checks++; if (!ok || lat != 18) begin errors++; $display("FAIL vec%0d_latency got=%0d ok=%0b exp=18", v, lat, ok); end
            checks++; if ({h, l, e} !== {6'(exp_h), 7'(exp_l), exp_err}) begin
                errors++; $display("FAIL vec%0d_value got=%0d/%0d err=%b exp=%0d/%0d err=%b", v, h, l, e, exp_h, exp_l, exp_err);
            end
        end
    endtask

    task automatic test_restart();
        int first_done = 0;
        logic [5:0] h; logic [6:0] l; logic e;
        h = '0; l = '0; e = 1'b0;
        pulse_start(4'd3, 4'd3, 4'd4, 4'd4);
        repeat (8) @(negedge clk);
        // second falling edge is sampled at cnt=9 and launches at cnt=10
        pulse_start(4'd4, 4'd2, 4'd0, 4'd1);
        model_conv(4, 2, 0, 1);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done && first_done == 0) begin first_done = i; h = h_val; l = l_val; e = err; end
        end
        checks++; if (first_done != 18) begin errors++; $display("FAIL restart_latency got=%0d exp=18", first_done); end
        checks++; if ({h, l, e} !== {6'(exp_h), 7'(exp_l), exp_err}) begin
            errors++; $display("FAIL restart_value got=%0d/%0d err=%b exp=%0d/%0d err=%b", h, l, e, exp_h, exp_l, exp_err);
        end
    endtask

    task automatic test_random();
        logic [3:0] d [0:3];
        logic [5:0] h; logic [6:0] l; logic e; int lat; bit ok;
        for (int n = 0; n < 24; n++) begin
            d[0] = 4'($urandom_range(0, 6));
            d[1] = 4'($urandom_range(0, 9));
            d[2] = 4'($urandom_range(0, 9));
            d[3] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) d[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
            run_conv(d[0], d[1], d[2], d[3], h, l, e, lat, ok);
            model_conv(d[0], d[1], d[2], d[3]);
            checks++; if (!ok || {h, l, e} !== {6'(exp_h), 7'(exp_l), exp_err}) begin
                errors++; $display("FAIL rand%0d digits=%h%h%h%h got=%0d/%0d err=%b ok=%0b exp=%0d/%0d err=%b",
                                   n, d[0], d[1], d[2], d[3], h, l, e, ok, exp_h, exp_l, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        pulse_start(4'd1, 4'd1, 4'd1, 4'd1);
        repeat (13) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        exp_h = 0; exp_l = 0; exp_err = 1'b0;
        checks++; if ({h_val, l_val} !== 13'd0) begin errors++; $display("FAIL rstmid_values got=%0d/%0d exp=0/0", h_val, l_val); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got=%b exp=000", {busy, done, err}); end
        @(negedge clk); start = 1'b1;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (busy || done || err || h_val != 6'd0 || l_val != 7'd0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_idle active_cycles=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_restart();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
